// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IFU and LSU share a single memory port with one
// transaction outstanding, alternating grants and a bounded response wait.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,

    input  logic            ifu_req_valid_i,
    output logic            ifu_req_ready_o,
    input  logic [XLEN-1:0] ifu_addr_i,
    output logic            ifu_resp_valid_o,
    output logic [XLEN-1:0] ifu_rdata_o,

    input  logic            lsu_req_valid_i,
    output logic            lsu_req_ready_o,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic            lsu_we_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    input  logic [3:0]      lsu_wmask_i,
    output logic            lsu_resp_valid_o,
    output logic [XLEN-1:0] lsu_rdata_o,

    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_wdata_o,
    output logic [3:0]      mem_wmask_o,
    input  logic            mem_resp_valid_i,
    input  logic [XLEN-1:0] mem_rdata_i,

    output logic            timeout_o
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t          state_q, state_d;
    owner_t          owner_q, last_grant_q;
    logic [XLEN-1:0] addr_q, wdata_q;
    logic            we_q;
    logic [3:0]      wmask_q;
    logic [7:0]      cnt_q;
    logic            timeout_q;

    logic grant_lsu, grant_ifu, accept, expired, resp_fire;

    // LSU has priority unless it was the last one served.
    assign grant_lsu = lsu_req_valid_i && (!ifu_req_valid_i || last_grant_q == OWN_IFU);
    assign grant_ifu = ifu_req_valid_i && !grant_lsu;
    assign accept    = (state_q == S_IDLE) && !rst_i && (grant_lsu || grant_ifu);
    assign expired   = (cnt_q == 8'(TIMEOUT - 1)) && !mem_resp_valid_i;
    assign resp_fire = (state_q == S_WAIT) && !rst_i && (mem_resp_valid_i || expired);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_REQ;
            S_REQ:   if (mem_req_ready_i) state_d = S_WAIT;
            S_WAIT:  if (mem_resp_valid_i || expired) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= OWN_IFU;
            owner_q      <= OWN_IFU;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            wmask_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q      <= grant_lsu ? OWN_LSU : OWN_IFU;
                last_grant_q <= grant_lsu ? OWN_LSU : OWN_IFU;
                addr_q       <= grant_lsu ? lsu_addr_i : ifu_addr_i;
                we_q         <= grant_lsu && lsu_we_i;
                wdata_q      <= grant_lsu ? lsu_wdata_i : '0;
                wmask_q      <= grant_lsu ? lsu_wmask_i : 4'b0000;
            end
            if (state_q == S_REQ && mem_req_ready_i)
                cnt_q <= '0;
            else if (state_q == S_WAIT)
                cnt_q <= cnt_q + 8'd1;
            if (state_q == S_WAIT && expired)
                timeout_q <= 1'b1;
        end
    end

    // Outputs are forced quiet while reset is held so an abandoned WAIT cannot pulse.
    assign ifu_req_ready_o  = (state_q == S_IDLE) && !rst_i && grant_ifu;
    assign lsu_req_ready_o  = (state_q == S_IDLE) && !rst_i && grant_lsu;

    assign mem_req_valid_o  = (state_q == S_REQ) && !rst_i;
    assign mem_addr_o       = {addr_q[XLEN-1:2], 2'b00};
    assign mem_we_o         = we_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_wmask_o      = wmask_q;

    assign ifu_resp_valid_o = resp_fire && (owner_q == OWN_IFU);
    assign lsu_resp_valid_o = resp_fire && (owner_q == OWN_LSU);
    assign ifu_rdata_o      = mem_resp_valid_i ? mem_rdata_i : '0;
    assign lsu_rdata_o      = mem_resp_valid_i ? mem_rdata_i : '0;

    assign timeout_o        = timeout_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, store stall, timeout and reset abandonment.
module tb_mem_arbiter;
    localparam int XLEN = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            ifu_req_valid_i, ifu_req_ready_o, ifu_resp_valid_o;
    logic [XLEN-1:0] ifu_addr_i, ifu_rdata_o;
    logic            lsu_req_valid_i, lsu_req_ready_o, lsu_we_i, lsu_resp_valid_o;
    logic [XLEN-1:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic [3:0]      lsu_wmask_i, mem_wmask_o;
    logic            mem_req_valid_o, mem_req_ready_i, mem_we_o, mem_resp_valid_i;
    logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic            timeout_o;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.XLEN(XLEN), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
        .ifu_addr_i(ifu_addr_i), .ifu_resp_valid_o(ifu_resp_valid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
        .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_wmask_i(lsu_wmask_i), .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_wmask_o(mem_wmask_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_rdata_i(mem_rdata_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen at the falling edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    // One full zero-wait transaction with both requesters held valid.
    task automatic grant_cycle(input logic exp_lsu, input logic [XLEN-1:0] rdata);
        settle();
        chk("grant_lsu_ready", XLEN'(lsu_req_ready_o), XLEN'(exp_lsu));
        chk("grant_ifu_ready", XLEN'(ifu_req_ready_o), XLEN'(!exp_lsu));
        tick();
        settle();
        chk("grant_mem_addr", mem_addr_o, exp_lsu ? 32'h0000_0200 : 32'h0000_0300);
        tick();
        mem_resp_valid_i = 1'b1;
        mem_rdata_i      = rdata;
        settle();
        chk("grant_lsu_resp", XLEN'(lsu_resp_valid_o), XLEN'(exp_lsu));
        chk("grant_ifu_resp", XLEN'(ifu_resp_valid_o), XLEN'(!exp_lsu));
        chk("grant_rdata", exp_lsu ? lsu_rdata_o : ifu_rdata_o, rdata);
        tick();
        mem_resp_valid_i = 1'b0;
    endtask

    initial begin
        ifu_req_valid_i = 0; ifu_addr_i = '0;
        lsu_req_valid_i = 0; lsu_addr_i = '0; lsu_we_i = 0; lsu_wdata_i = '0; lsu_wmask_i = '0;
        mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_rdata_i = '0;
        rst_i = 1'b1;
        #1;

        // Reset: ready/valid outputs held low even with requests pending
        ifu_req_valid_i = 1; lsu_req_valid_i = 1;
        tick();
        settle();
        chk("rst_ifu_ready", XLEN'(ifu_req_ready_o), 0);
        chk("rst_lsu_ready", XLEN'(lsu_req_ready_o), 0);
        chk("rst_mem_valid", XLEN'(mem_req_valid_o), 0);
        chk("rst_timeout", XLEN'(timeout_o), 0);
        tick();
        rst_i = 0; ifu_req_valid_i = 0; lsu_req_valid_i = 0;

        // IFU-only load, unaligned address
        ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0003; mem_req_ready_i = 1;
        settle();
        chk("ifu_ready", XLEN'(ifu_req_ready_o), 1);
        chk("ifu_lsu_ready", XLEN'(lsu_req_ready_o), 0);
        tick();
        ifu_req_valid_i = 0;
        settle();
        chk("ifu_mem_valid", XLEN'(mem_req_valid_o), 1);
        chk("ifu_mem_addr", mem_addr_o, 32'h8000_0000);
        chk("ifu_mem_we", XLEN'(mem_we_o), 0);
        chk("ifu_mem_wmask", XLEN'(mem_wmask_o), 0);
        tick();
        mem_resp_valid_i = 1; mem_rdata_i = 32'hDEAD_BEEF;
        settle();
        chk("ifu_wait_mem_valid", XLEN'(mem_req_valid_o), 0);
        chk("ifu_resp_valid", XLEN'(ifu_resp_valid_o), 1);
        chk("ifu_rdata", ifu_rdata_o, 32'hDEAD_BEEF);
        chk("ifu_lsu_resp", XLEN'(lsu_resp_valid_o), 0);
        tick();
        mem_resp_valid_i = 0;
        settle();
        chk("ifu_resp_pulse_end", XLEN'(ifu_resp_valid_o), 0);

        // Alternating grants, both held valid after a fresh reset
        do_reset();
        ifu_req_valid_i = 1; ifu_addr_i = 32'h0000_0300;
        lsu_req_valid_i = 1; lsu_addr_i = 32'h0000_0200; lsu_we_i = 0;
        mem_req_ready_i = 1;
        grant_cycle(1'b1, 32'h1111_1111);
        grant_cycle(1'b0, 32'h2222_2222);
        grant_cycle(1'b1, 32'h3333_3333);
        ifu_req_valid_i = 0; lsu_req_valid_i = 0;

        // LSU store stalled by memory for three cycles
        lsu_req_valid_i = 1; lsu_addr_i = 32'h0000_0104; lsu_we_i = 1;
        lsu_wdata_i = 32'h00AB_0000; lsu_wmask_i = 4'b0100; mem_req_ready_i = 0;
        settle();
        chk("st_lsu_ready", XLEN'(lsu_req_ready_o), 1);
        tick();
        lsu_req_valid_i = 0; lsu_we_i = 0; lsu_wdata_i = '0; lsu_wmask_i = '0; lsu_addr_i = '0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("st_hold_valid", XLEN'(mem_req_valid_o), 1);
            chk("st_hold_addr", mem_addr_o, 32'h0000_0104);
            chk("st_hold_we", XLEN'(mem_we_o), 1);
            chk("st_hold_wdata", mem_wdata_o, 32'h00AB_0000);
            chk("st_hold_wmask", XLEN'(mem_wmask_o), 32'h4);
            tick();
        end
        mem_req_ready_i = 1;
        settle();
        chk("st_hs_valid", XLEN'(mem_req_valid_o), 1);
        tick();
        mem_req_ready_i = 0;
        settle();
        chk("st_single_hs", XLEN'(mem_req_valid_o), 0);
        chk("st_no_early_resp", XLEN'(lsu_resp_valid_o), 0);
        tick();
        mem_resp_valid_i = 1;
        settle();
        chk("st_lsu_ack", XLEN'(lsu_resp_valid_o), 1);
        chk("st_ifu_resp", XLEN'(ifu_resp_valid_o), 0);
        tick();
        mem_resp_valid_i = 0;

        // Spurious response in IDLE
        mem_resp_valid_i = 1; mem_rdata_i = 32'hBAD0_BAD0;
        settle();
        chk("spur_ifu_resp", XLEN'(ifu_resp_valid_o), 0);
        chk("spur_lsu_resp", XLEN'(lsu_resp_valid_o), 0);
        tick();
        settle();
        chk("spur_mem_valid", XLEN'(mem_req_valid_o), 0);
        tick();
        mem_resp_valid_i = 0;

        // Timeout after four WAIT cycles with no response
        ifu_req_valid_i = 1; ifu_addr_i = 32'h0000_0040; mem_req_ready_i = 1;
        settle();
        chk("to_ifu_ready", XLEN'(ifu_req_ready_o), 1);
        tick();
        ifu_req_valid_i = 0;
        tick();
        mem_req_ready_i = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("to_wait_no_resp", XLEN'(ifu_resp_valid_o), 0);
            chk("to_wait_flag", XLEN'(timeout_o), 0);
            tick();
        end
        settle();
        chk("to_resp_valid", XLEN'(ifu_resp_valid_o), 1);
        chk("to_rdata_zero", ifu_rdata_o, 0);
        chk("to_lsu_resp", XLEN'(lsu_resp_valid_o), 0);
        tick();
        settle();
        chk("to_flag_set", XLEN'(timeout_o), 1);
        chk("to_resp_end", XLEN'(ifu_resp_valid_o), 0);

        // Reset during WAIT abandons the transaction
        lsu_req_valid_i = 1; lsu_addr_i = 32'h0000_0080; mem_req_ready_i = 1;
        tick();
        lsu_req_valid_i = 0;
        tick();
        mem_req_ready_i = 0;
        settle();
        chk("rw_flag_sticky", XLEN'(timeout_o), 1);
        chk("rw_in_wait", XLEN'(mem_req_valid_o), 0);
        tick();
        rst_i = 1; mem_resp_valid_i = 1; mem_rdata_i = 32'hCAFE_F00D;
        settle();
        chk("rw_rst_no_resp", XLEN'(lsu_resp_valid_o), 0);
        tick();
        rst_i = 0;
        settle();
        chk("rw_late_no_resp", XLEN'(lsu_resp_valid_o), 0);
        chk("rw_flag_clear", XLEN'(timeout_o), 0);
        chk("rw_idle", XLEN'(mem_req_valid_o), 0);
        tick();
        mem_resp_valid_i = 0;

        // Normal service after the abandoned transaction
        ifu_req_valid_i = 1; ifu_addr_i = 32'h0000_0010; mem_req_ready_i = 1;
        settle();
        chk("post_ifu_ready", XLEN'(ifu_req_ready_o), 1);
        tick();
        ifu_req_valid_i = 0;
        settle();
        chk("post_mem_addr", mem_addr_o, 32'h0000_0010);
        tick();
        mem_resp_valid_i = 1; mem_rdata_i = 32'h1234_5678;
        settle();
        chk("post_resp", XLEN'(ifu_resp_valid_o), 1);
        chk("post_rdata", ifu_rdata_o, 32'h1234_5678);
        tick();
        mem_resp_valid_i = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
